// File: rtl/alu_seq_ctrl.sv
// Purpose : multi-cycle command sequencer that owns a register file and drives an external ALU.
// Latency : accept edge T -> res_valid in cycle T+3 (legal opcode), T+1 (illegal opcode).
// Backpr. : cmd_ready only in IDLE; response held stable in RESP until res_ready.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake; cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
//                            cmd_use_imm, cmd_imm latched on the accepting edge
//   alu_in_a, alu_in_b,      registered operands and opcode presented to the external ALU
//   alu_opcode
//   alu_out, alu_flags       ALU result and {overflow,negative,zero}, sampled in EXEC only
//   res_valid / res_ready    response handshake; res_data, res_flags, res_err
//   status_flags             flags of the last legal completed command (sticky)
module alu_seq_ctrl #(
    parameter int BW   = 16,
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [RW-1:0] cmd_dst,
    input  logic [RW-1:0] cmd_src_a,
    input  logic [RW-1:0] cmd_src_b,
    input  logic          cmd_use_imm,
    input  logic [BW-1:0] cmd_imm,
    output logic [BW-1:0] alu_in_a,
    output logic [BW-1:0] alu_in_b,
    output logic [3:0]    alu_opcode,
    input  logic [BW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [BW-1:0] res_data,
    output logic [2:0]    res_flags,
    output logic          res_err,
    output logic [2:0]    status_flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    state;

    // Command fields captured at accept; the source is free to change its
    // inputs once the handshake has completed.
    logic [3:0]    op_q;
    logic [RW-1:0] dst_q;
    logic [RW-1:0] src_a_q;
    logic [RW-1:0] src_b_q;
    logic          use_imm_q;
    logic [BW-1:0] imm_q;

    logic [BW-1:0] rf [NREG];

    logic          cmd_fire;
    logic          res_fire;

    assign cmd_ready = (state == S_IDLE);
    assign res_valid = (state == S_RESP);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign res_fire  = res_valid && res_ready;

    // Control path and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= '0;
            dst_q        <= '0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            use_imm_q    <= 1'b0;
            imm_q        <= '0;
            alu_in_a     <= '0;
            alu_in_b     <= '0;
            alu_opcode   <= '0;
            res_data     <= '0;
            res_flags    <= '0;
            res_err      <= 1'b0;
            status_flags <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        op_q      <= cmd_op;
                        dst_q     <= cmd_dst;
                        src_a_q   <= cmd_src_a;
                        src_b_q   <= cmd_src_b;
                        use_imm_q <= cmd_use_imm;
                        imm_q     <= cmd_imm;
                        // Opcodes 8-15 skip the ALU entirely and report an
                        // error with a zeroed payload.
                        if (cmd_op[3]) begin
                            res_err   <= 1'b1;
                            res_data  <= '0;
                            res_flags <= '0;
                            state     <= S_RESP;
                        end else begin
                            state     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // Operands are read here, one cycle before write-back,
                    // so dst aliasing a source register is harmless.
                    alu_in_a   <= rf[src_a_q];
                    alu_in_b   <= use_imm_q ? imm_q : rf[src_b_q];
                    alu_opcode <= op_q;
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    // The ALU is combinational on the registered inputs, so
                    // its output has settled by the end of this cycle.
                    res_data     <= alu_out;
                    res_flags    <= alu_flags;
                    res_err      <= 1'b0;
                    status_flags <= alu_flags;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (res_fire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file: single write port, active only in EXEC. Reset clears
    // every entry, and a reset during EXEC wins over the write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (state == S_EXEC) begin
            rf[dst_q] <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Purpose : directed self-checking bench for alu_seq_ctrl with a behavioural ALU.
// Latency : measures accept-to-response cycles for legal and illegal opcodes.
// Backpr. : exercises held responses (res_ready low) while a new command waits.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src_a;
    logic [2:0]  cmd_src_b;
    logic        cmd_use_imm;
    logic [15:0] cmd_imm;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_out;
    logic [2:0]  alu_flags;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_flags;
    logic        res_err;
    logic [2:0]  status_flags;

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl #(.BW(16), .NREG(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dst      (cmd_dst),
        .cmd_src_a    (cmd_src_a),
        .cmd_src_b    (cmd_src_b),
        .cmd_use_imm  (cmd_use_imm),
        .cmd_imm      (cmd_imm),
        .alu_in_a     (alu_in_a),
        .alu_in_b     (alu_in_b),
        .alu_opcode   (alu_opcode),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_flags    (res_flags),
        .res_err      (res_err),
        .status_flags (status_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 inc a, 6 shl a, 7 pass b.
    // Flags are {overflow, negative, zero}; overflow only for add/sub/inc.
    always_comb begin
        logic [15:0] r;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (alu_opcode[2:0])
            3'd0: begin r = alu_in_a + alu_in_b;
                  ov = (alu_in_a[15] == alu_in_b[15]) && (r[15] != alu_in_a[15]); end
            3'd1: begin r = alu_in_a - alu_in_b;
                  ov = (alu_in_a[15] != alu_in_b[15]) && (r[15] != alu_in_a[15]); end
            3'd2: r = alu_in_a & alu_in_b;
            3'd3: r = alu_in_a | alu_in_b;
            3'd4: r = alu_in_a ^ alu_in_b;
            3'd5: begin r = alu_in_a + 16'd1; ov = (alu_in_a == 16'h7FFF); end
            3'd6: r = {alu_in_a[14:0], 1'b0};
            default: r = alu_in_b;
        endcase
        alu_out   = r;
        alu_flags = {ov, r[15], (r == 16'h0000)};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] sa,
                             input logic [2:0] sb, input logic ui, input logic [15:0] imm);
        cmd_op      = op;
        cmd_dst     = dst;
        cmd_src_a   = sa;
        cmd_src_b   = sb;
        cmd_use_imm = ui;
        cmd_imm     = imm;
        cmd_valid   = 1'b1;
    endtask

    // Called at the negedge right after the accepting posedge. Counts posedges
    // from the accept edge (inclusive) until res_valid is seen, bounded.
    task automatic wait_res(output int lat);
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Full transaction with res_ready high; returns at the negedge after the
    // response handshake, when the DUT is back in IDLE.
    task automatic issue(input string tag, input logic [3:0] op, input logic [2:0] dst,
                         input logic [2:0] sa, input logic [2:0] sb, input logic ui,
                         input logic [15:0] imm, input logic [15:0] ed, input logic [2:0] ef,
                         input logic ee, input int elat);
        int lat;
        @(negedge clk);
        drive_cmd(op, dst, sa, sb, ui, imm);
        check({tag, ".cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_res(lat);
        check({tag, ".latency"}, lat, elat);
        check({tag, ".res_data"}, {16'd0, res_data}, {16'd0, ed});
        check({tag, ".res_flags"}, {29'd0, res_flags}, {29'd0, ef});
        check({tag, ".res_err"}, {31'd0, res_err}, {31'd0, ee});
        @(posedge clk);
        @(negedge clk);
        check({tag, ".idle"}, {31'd0, res_valid}, 32'd0);
    endtask

    // Register read-back: rX = rX | 0 leaves the entry unchanged.
    task automatic read_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
        issue(tag, 4'd3, idx, idx, 3'd0, 1'b1, 16'h0000, exp,
              {1'b0, exp[15], (exp == 16'h0000)}, 1'b0, 3);
    endtask

    initial begin
        int lat;
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1;
        cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
        cmd_use_imm = 1'b0; cmd_imm = '0;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst.res_valid", {31'd0, res_valid}, 32'd0);
        check("rst.status", {29'd0, status_flags}, 32'd0);
        check("rst.alu_in_a", {16'd0, alu_in_a}, 32'd0);
        check("rst.alu_opcode", {28'd0, alu_opcode}, 32'd0);
        check("rst.res_data", {16'd0, res_data}, 32'd0);
        for (int i = 0; i < 8; i++) read_reg("rst.rf", 3'(i), 16'h0000);

        // 2: signed overflow on add
        issue("ld_r1", 4'd7, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 16'h7FFF, 3'b000, 1'b0, 3);
        issue("ld_r2", 4'd7, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001, 16'h0001, 3'b000, 1'b0, 3);
        issue("add_r3", 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h8000, 3'b110, 1'b0, 3);
        check("add.status", {29'd0, status_flags}, {29'd0, 3'b110});
        read_reg("rd_r3", 3'd3, 16'h8000);

        // 3: zero result on sub
        issue("sub_r4", 4'd1, 3'd4, 3'd2, 3'd2, 1'b0, 16'h0000, 16'h0000, 3'b001, 1'b0, 3);
        check("sub.status", {29'd0, status_flags}, {29'd0, 3'b001});

        // 4: illegal opcode, aimed at r3
        issue("illegal", 4'b1000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b1, 1);
        check("illegal.status", {29'd0, status_flags}, {29'd0, 3'b001});
        read_reg("illegal.r3", 3'd3, 16'h8000);

        // 5: held response while another command waits. r6 = r1 & r2 = 1.
        @(negedge clk);
        res_ready = 1'b0;
        drive_cmd(4'd2, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_res(lat);
        check("hold.latency", lat, 3);
        drive_cmd(4'd7, 3'd7, 3'd0, 3'd0, 1'b1, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold.res_valid", {31'd0, res_valid}, 32'd1);
            check("hold.res_data", {16'd0, res_data}, 32'h0001);
            check("hold.res_flags", {29'd0, res_flags}, 32'd0);
            check("hold.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold.release", {31'd0, res_valid}, 32'd0);
        check("hold.next_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_res(lat);
        check("next.latency", lat, 3);
        check("next.res_data", {16'd0, res_data}, 32'h1234);
        @(posedge clk);
        read_reg("rd_r6", 3'd6, 16'h0001);
        read_reg("rd_r7", 3'd7, 16'h1234);

        // 6: reset during EXEC of r5 = r1 + 1
        @(negedge clk);
        drive_cmd(4'd5, 3'd5, 3'd1, 3'd0, 1'b0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("exec_rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("exec_rst.res_valid", {31'd0, res_valid}, 32'd0);
        check("exec_rst.status", {29'd0, status_flags}, 32'd0);
        read_reg("exec_rst.r5", 3'd5, 16'h0000);
        read_reg("exec_rst.r1", 3'd1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
